// File: rtl/fib_seq_gen.sv
// fib_seq_gen: Fibonacci-class sequence generator with valid/ready output.
// A run starts from two latched seeds and emits num_terms terms of
// f(n) = f(n-1) + f(n-2). Each register carries a carry tag, so every term
// after an unsigned overflow is marked. In wrap mode the tagged terms are
// still emitted, modulo 2^WIDTH. In stop mode the run ends before a tagged
// term is presented.
module fib_seq_gen #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] seed0,
  input  logic [WIDTH-1:0] seed1,
  input  logic [CNT_W-1:0] num_terms,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] r0, r1;
  logic             c0, c1;
  logic [CNT_W-1:0] idx;
  logic [CNT_W-1:0] num_q;
  logic             mode_q;
  logic             ovf_q;

  logic             accept;
  logic             xfer;
  logic             last_term;
  logic             stop_hit;
  logic [WIDTH:0]   sum;
  logic [CNT_W-1:0] idx_inc;

  // The outputs are decoded straight from registers, so out_ready has no path to them.
  assign out_data  = r0;
  assign out_valid = (state == RUN);
  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign ovf       = ovf_q;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // This block computes the next state, the run-control strobes and the next-term sum.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    xfer       = 1'b0;
    stop_hit   = 1'b0;
    sum        = {1'b0, r0} + {1'b0, r1};
    idx_inc    = idx + 1'b1;
    last_term  = (idx_inc == num_q);
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = (num_terms == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (out_ready) begin
          xfer = 1'b1;
          if (last_term) begin
            state_next = DONE;
          end else if (c1 && mode_q) begin
            // The term that would be presented next is tagged, and stop mode
            // ends the run before that term is shown.
            stop_hit   = 1'b1;
            state_next = DONE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The datapath loads seeds on an accepted start and advances one term per transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r0     <= '0;
      r1     <= '0;
      c0     <= 1'b0;
      c1     <= 1'b0;
      idx    <= '0;
      num_q  <= '0;
      mode_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      r0     <= seed0;
      r1     <= seed1;
      c0     <= 1'b0;
      c1     <= 1'b0;
      idx    <= '0;
      num_q  <= num_terms;
      mode_q <= mode;
      ovf_q  <= 1'b0;
    end else if (xfer) begin
      r0  <= r1;
      c0  <= c1;
      r1  <= sum[WIDTH-1:0];
      c1  <= sum[WIDTH] | c0 | c1;
      idx <= idx_inc;
      // Wrap mode sets the flag when a tagged term is accepted.
      // Stop mode sets it when the run is cut short.
      if (stop_hit || (!mode_q && c0)) begin
        ovf_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fib_seq_gen.sv
// tb_fib_seq_gen: scoreboard bench for fib_seq_gen. The stimulus pushes the
// hand-computed terms it expects into a queue. A monitor pops one entry for
// every term the DUT hands over.
module tb_fib_seq_gen;

  logic       clk;
  logic       rst;
  logic       start;
  logic       mode;
  logic [5:0] seed0;
  logic [5:0] seed1;
  logic [7:0] num_terms;
  logic [5:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;
  logic       ovf;

  int tests_run  = 0;
  int fail_count = 0;
  int exp_q[$];

  fib_seq_gen #(.WIDTH(6), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .seed0     (seed0),
    .seed1     (seed1),
    .num_terms (num_terms),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .ovf       (ovf)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // This watchdog stops a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  // The monitor samples on the falling edge. Each handshake seen there is the transfer at the next rising edge.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_term", int'(out_data), -1);
      end else begin
        checkOutput("stream_term", int'(out_data), exp_q.pop_front());
      end
    end
  end

  // This task issues a one-cycle start pulse. It returns 1 unit after the edge that sampled the pulse.
  task automatic applyStimulus(input logic [5:0] s0, input logic [5:0] s1,
                               input logic [7:0] n, input logic m);
    @(posedge clk); #1;
    seed0     = s0;
    seed1     = s1;
    num_terms = n;
    mode      = m;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // This task waits for done, with a bounded wait. It then checks that the pulse lasts one cycle and that every expected term was seen.
  task automatic waitDone(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (done) seen = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    checkOutput({name, "_done_seen"}, int'(seen), 1);
    checkOutput({name, "_valid_at_done"}, int'(out_valid), 0);
    checkOutput({name, "_busy_at_done"}, int'(busy), 0);
    checkOutput({name, "_terms_left"}, exp_q.size(), 0);
    @(posedge clk); #1;
    checkOutput({name, "_done_one_cycle"}, int'(done), 0);
  endtask

  task automatic waitForTerm(input int value, input string name);
    bit found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (out_valid && out_data == 6'(value)) found = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    checkOutput({name, "_found"}, int'(found), 1);
  endtask

  initial begin
    int basic[10] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34};
    int wrap[13]  = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 25, 16};
    int bp[5]     = '{3, 4, 7, 11, 18};

    rst       = 1'b0;
    start     = 1'b0;
    mode      = 1'b0;
    seed0     = '0;
    seed1     = '0;
    num_terms = '0;
    out_ready = 1'b1;

    // Reset state.
    #12;
    checkOutput("reset_data", int'(out_data), 0);
    checkOutput("reset_valid", int'(out_valid), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_ovf", int'(ovf), 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Basic run. A start pulse mid-run must be ignored.
    foreach (basic[i]) exp_q.push_back(basic[i]);
    applyStimulus(6'd0, 6'd1, 8'd10, 1'b0);
    checkOutput("basic_start_busy", int'(busy), 1);
    checkOutput("basic_start_valid", int'(out_valid), 1);
    checkOutput("basic_start_data", int'(out_data), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    seed0 = 6'd7; seed1 = 6'd7; num_terms = 8'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    waitDone("basic");
    checkOutput("basic_ovf", int'(ovf), 0);

    // Wrap mode: ovf must rise on the transfer of 25 and stay set afterwards.
    foreach (wrap[i]) exp_q.push_back(wrap[i]);
    applyStimulus(6'd0, 6'd1, 8'd13, 1'b0);
    waitForTerm(25, "wrap25");
    checkOutput("wrap_ovf_before_25", int'(ovf), 0);
    @(posedge clk); #1;
    checkOutput("wrap_ovf_after_25", int'(ovf), 1);
    waitDone("wrap");
    checkOutput("wrap_ovf_sticky", int'(ovf), 1);

    // Stop mode: only 0..55 may appear, then done and ovf are both set.
    for (int i = 0; i < 11; i++) exp_q.push_back(wrap[i]);
    applyStimulus(6'd0, 6'd1, 8'd13, 1'b1);
    waitForTerm(55, "stop55");
    checkOutput("stop_ovf_before", int'(ovf), 0);
    @(posedge clk); #1;
    checkOutput("stop_done_with_ovf", int'(done), 1);
    checkOutput("stop_ovf", int'(ovf), 1);
    waitDone("stop");

    // Back-pressure: the term 7 is held for three cycles.
    foreach (bp[i]) exp_q.push_back(bp[i]);
    applyStimulus(6'd3, 6'd4, 8'd5, 1'b0);
    waitForTerm(7, "bp7");
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput("bp_hold_data", int'(out_data), 7);
      checkOutput("bp_hold_valid", int'(out_valid), 1);
    end
    out_ready = 1'b1;
    waitDone("bp");

    // num_terms = 0: done follows start directly and no term is presented.
    applyStimulus(6'd5, 6'd6, 8'd0, 1'b0);
    checkOutput("zero_done", int'(done), 1);
    checkOutput("zero_valid", int'(out_valid), 0);
    waitDone("zero");

    // num_terms = 1: a single term, 9.
    exp_q.push_back(9);
    applyStimulus(6'd9, 6'd2, 8'd1, 1'b0);
    waitDone("one");

    // Reset mid-run aborts the run with no done pulse.
    foreach (basic[i]) exp_q.push_back(basic[i]);
    applyStimulus(6'd0, 6'd1, 8'd10, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    checkOutput("midrst_data", int'(out_data), 0);
    checkOutput("midrst_valid", int'(out_valid), 0);
    checkOutput("midrst_busy", int'(busy), 0);
    checkOutput("midrst_done", int'(done), 0);
    exp_q.delete();
    @(posedge clk); #1;
    checkOutput("midrst_no_done", int'(done), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("after_rst_done", int'(done), 0);

    // A clean restart with new seeds.
    exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(5); exp_q.push_back(8);
    applyStimulus(6'd2, 6'd3, 8'd4, 1'b0);
    checkOutput("restart_first", int'(out_data), 2);
    waitDone("restart");
    checkOutput("restart_ovf", int'(ovf), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule

// File: doc/fib_seq_gen.md
# fib_seq_gen

Parametrised Fibonacci-class sequence generator: on a start request it latches two seeds and a term count, then streams `num_terms` terms of f(n)=f(n-1)+f(n-2) over a valid/ready output port at up to one term per cycle. It is the next generation of the lab's fixed 6-bit Fibonacci unit. It adds:
- configurable width;
- a bounded run length;
- carry-based overflow detection with wrap or stop modes;
- back-pressure.

It sits between the lab's register/ALU datapath and any downstream consumer, such as a display driver or a FIFO.

## Interface
- `WIDTH`, 6, term width in bits.
- `CNT_W`, 8, width of the term counter and `num_terms`.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted at 0).
- `start`  in  1  request a run; sampled only in IDLE.
- `mode`  in  1  0 = wrap on overflow, 1 = stop on overflow; latched with `start`.
- `seed0`  in  WIDTH  term 0; latched with `start`.
- `seed1`  in  WIDTH  term 1; latched with `start`.
- `num_terms`  in  CNT_W  number of terms to emit; latched with `start`.
- `out_data`  out  WIDTH  current term.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer accepts the term.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle pulse at end of run.
- `ovf`  out  1  sticky overflow flag for the current or last run.

## Operation
- States:
  - IDLE → RUN on `start`=1 with `num_terms`≠0.
  - IDLE → DONE on `start`=1 with `num_terms`=0.
  - RUN → DONE after the last term is accepted, or on a stop-mode overflow.
  - DONE → IDLE unconditionally after one cycle.
- Datapath registers:
  - `r0` holds the current term and `r1` the next term, each WIDTH bits.
  - Each register has a carry tag, `c0` and `c1`.
  - `idx` is a CNT_W-bit count of accepted terms.
- On accepted `start`:
  - Load `r0`=`seed0`, `r1`=`seed1`, `c0`=`c1`=0, `idx`=0.
  - Clear `ovf`, latch `mode` and `num_terms`.
- Transfer occurs when `out_valid`&&`out_ready` at a rising edge. On transfer:
  - `r0`←`r1`, `c0`←`c1`.
  - {carry,`r1`}←{1'b0,`r0`}+{1'b0,`r1`}; `c1`←carry|`c0`|`c1`. The tag propagates, so every term after an overflow is tagged.
  - `idx`←`idx`+1.
- Ending the run:
  - If `idx`+1 = latched `num_terms`, go to DONE.
  - Otherwise, if the new `c0`=1 and mode=1, go to DONE without presenting that term, and set `ovf`=1.
- Mode 0:
  - A tagged term is emitted as its low WIDTH bits (modulo 2^WIDTH).
  - `ovf` is set on the transfer of the first tagged term.
- `ovf` holds its value through DONE and IDLE until the next accepted `start`.
- `start` is ignored in RUN and DONE; there is no queueing.
- Seeds are never tagged. Sums are unsigned only.

## Timing
- Reset values (asynchronous, while `rst`=0):
  - State = IDLE.
  - `out_data`=0, `out_valid`=0, `busy`=0, `done`=0, `ovf`=0.
  - All internal registers = 0.
- Reset mid-run aborts immediately. No `done` pulse is generated, and the output is dropped.
- Start latency: `start` is sampled at edge k. At edge k+1 the outputs are `busy`=1, `out_valid`=1, `out_data`=`seed0`.
- `out_data` equals `r0`, taken from registers (no combinational path from `out_ready`).
- Back-pressure:
  - While `out_valid`=1 and `out_ready`=0, `out_data` is held stable and no state advances.
- Throughput is one term per cycle while `out_ready`=1.
- End of run:
  - The last transfer occurs at edge t.
  - Edge t+1: `out_valid`=0, `busy`=0, `done`=1.
  - Edge t+2: `done`=0, state IDLE.
- `num_terms`=0: the start edge goes directly to DONE. `done`=1 one cycle after `start`, with no `out_valid`.
- Stop-mode overflow: `out_valid` drops at the same edge that DONE is entered. `ovf` and `done` become 1 together.
- Earliest restart: `start` is accepted at the IDLE edge following DONE. The minimum gap between runs is 2 cycles.

## Test plan
- Basic run (WIDTH=6, mode 0): `seed0`=0, `seed1`=1, `num_terms`=10, `out_ready`=1.
  - Required: 0,1,1,2,3,5,8,13,21,34 on consecutive cycles.
  - `done` pulses once, then `ovf`=0.
- Wrap (mode 0): same seeds, `num_terms`=13.
  - Required: …,34,55,25,16, where 89 mod 64=25 and 144 mod 64=16.
  - `ovf`=1 from the transfer of 25 onward, and still 1 after `done`.
- Stop (mode 1): same seeds, `num_terms`=13.
  - Required: exactly 11 terms, 0 through 55, then `done`=1 with `ovf`=1.
  - 89/25 is never presented.
- Back-pressure: `seed0`=3, `seed1`=4, `num_terms`=5; hold `out_ready`=0 for 3 cycles while `out_data`=7.
  - Required: `out_data` stays 7 and `out_valid`=1 throughout.
  - The stream completes as 3,4,7,11,18.
- Edge counts:
  - `num_terms`=0 → no `out_valid`, `done` 1 cycle after `start`.
  - `num_terms`=1 with `seed0`=9 → a single term 9, then `done`.
- Reset and ignored start:
  - Pulse `start` during RUN → no effect on the stream.
  - Drive `rst`=0 mid-run → all outputs 0 immediately and no `done`.
  - A new `start` after release runs cleanly from the new seeds.
